// File: rtl/spi_slave_regif.sv
// Register-access protocol layer between spi_slave and an 8-bit register bus.
// The first word of a frame is a command (bit 7 = read, low bits = start address); later words stream with auto-increment.
module spi_slave_regif #(
  parameter int          ADDR_W   = 7,
  parameter logic [7:0]  RD_DUMMY = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              rx_ack,
  input  logic              first_byte,
  input  logic              last_byte,
  output logic              last_ack,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rd_data,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_ISSUE,
    RD_LOAD,
    RD_WAIT
  } state_t;

  state_t            state, state_next;
  logic              holdoff, holdoff_next;
  logic              last_holdoff, last_holdoff_next;
  logic              rx_ack_next, last_ack_next, reg_wr_next, reg_rd_next;
  logic              busy_next, frame_done_next;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        wr_data_next, tx_next;
  logic              accept, end_req;

  // spi_slave keeps rdy/last_byte high for one cycle after our ack, so that cycle is masked.
  assign accept  = rx_rdy && !holdoff;
  assign end_req = last_byte && !last_holdoff;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state        <= IDLE;
      holdoff      <= 1'b0;
      last_holdoff <= 1'b0;
      rx_ack       <= 1'b0;
      last_ack     <= 1'b0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      reg_addr     <= '0;
      reg_wr_data  <= 8'h00;
      tx_data      <= RD_DUMMY;
    end else begin
      state        <= state_next;
      holdoff      <= holdoff_next;
      last_holdoff <= last_holdoff_next;
      rx_ack       <= rx_ack_next;
      last_ack     <= last_ack_next;
      reg_wr       <= reg_wr_next;
      reg_rd       <= reg_rd_next;
      busy         <= busy_next;
      frame_done   <= frame_done_next;
      reg_addr     <= addr_next;
      reg_wr_data  <= wr_data_next;
      tx_data      <= tx_next;
    end
  end

  always_comb begin
    state_next        = state;
    holdoff_next      = 1'b0;
    last_holdoff_next = 1'b0;
    rx_ack_next       = 1'b0;
    last_ack_next     = 1'b0;
    reg_wr_next       = 1'b0;
    busy_next         = busy;
    frame_done_next   = 1'b0;
    addr_next         = reg_addr;
    wr_data_next      = reg_wr_data;
    tx_next           = tx_data;

    // Address advances in the cycle after each write strobe.
    if (reg_wr) addr_next = reg_addr + ADDR_W'(1);

    case (state)
      RD_ISSUE: state_next = RD_LOAD;
      RD_LOAD: begin
        tx_next    = reg_rd_data;
        addr_next  = reg_addr + ADDR_W'(1);
        state_next = RD_WAIT;
      end
      default: ;
    endcase

    // A received word always wins over frame end; last_byte is handled a cycle later.
    if (accept) begin
      rx_ack_next  = 1'b1;
      holdoff_next = 1'b1;
      if (first_byte || state == IDLE) begin
        addr_next  = rx_data[ADDR_W-1:0];
        busy_next  = 1'b1;
        tx_next    = RD_DUMMY;
        state_next = rx_data[7] ? RD_ISSUE : WR_WAIT;
      end else if (state == WR_WAIT) begin
        wr_data_next = rx_data;
        reg_wr_next  = 1'b1;
      end else if (state == RD_WAIT) begin
        state_next = RD_ISSUE;
      end
    end else if (end_req) begin
      last_ack_next     = 1'b1;
      last_holdoff_next = 1'b1;
      frame_done_next   = 1'b1;
      busy_next         = 1'b0;
      tx_next           = RD_DUMMY;
      state_next        = IDLE;
    end

    reg_rd_next = (state_next == RD_ISSUE);
  end

endmodule

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
Register-access protocol controller sitting between spi_slave and an internal 8-bit register bus. It consumes received words via the rdy/rdy_ack handshake and decodes the first word of each frame as a command: R/W flag plus start address. It then sequences register writes or reads with address auto-increment, supplies the next transmit word on spi_slave bus_in, and closes the frame on the last_byte indication.

Parameters:
ADDR_W, 7, register address width (1..7); the command byte carries addr in bits [ADDR_W-1:0].
RD_DUMMY, 8'hFF, tx_data value driven while no read data is loaded.

Ports:
clk  input  1  system clock, same clock as spi_slave clk
rst  input  1  synchronous active-high reset
en  input  1  block enable; low acts as synchronous reset of state and outputs
rx_data  input  8  received word (spi_slave bus_out)
rx_rdy  input  1  received word pending (spi_slave rdy), level
rx_ack  output  1  one-cycle consume pulse (to spi_slave rdy_ack)
first_byte  input  1  spi_slave first_byte, high while current word is the frame's first
last_byte  input  1  spi_slave last_byte, level: ss deasserted, frame ended
last_ack  output  1  one-cycle pulse acknowledging last_byte (to last_byte_ack)
tx_data  output  8  next word to shift out (to spi_slave bus_in)
reg_addr  output  ADDR_W  register bus address
reg_wr_data  output  8  register write data
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe
reg_rd_data  input  8  read data, valid exactly 1 cycle after reg_rd
busy  output  1  high from command accepted until frame end
frame_done  output  1  one-cycle pulse when a frame closes

Behaviour:
- Reset/en low: state IDLE; rx_ack=0, last_ack=0, reg_wr=0, reg_rd=0, busy=0, frame_done=0, reg_addr=0, reg_wr_data=0, tx_data=RD_DUMMY, holdoff=0.
- Word accept: when rx_rdy=1 and holdoff=0, pulse rx_ack for 1 cycle and set holdoff for the following cycle. rx_rdy is ignored during holdoff, because spi_slave drops rdy one cycle after the ack. Exactly one rx_ack per received word.
- States:
  - IDLE. Accepted word is a command if first_byte=1 or state is IDLE. cmd[7]=1 gives RD_ISSUE; cmd[7]=0 gives WR_WAIT. reg_addr<=cmd[ADDR_W-1:0]; busy<=1.
  - WR_WAIT. Each accepted data word: reg_wr_data<=rx_data, reg_wr=1 in the next cycle at the current reg_addr. In the cycle after the strobe, reg_addr<=reg_addr+1 (mod 2^ADDR_W).
  - RD_ISSUE. reg_rd=1 for 1 cycle at reg_addr, then go to RD_LOAD.
  - RD_LOAD. tx_data<=reg_rd_data; reg_addr<=reg_addr+1; go to RD_WAIT. Latency from command accept to tx_data valid is 3 clk cycles.
  - RD_WAIT. Each accepted word (MOSI content discarded) goes to RD_ISSUE and prefetches the next address.
- Resync: an accepted word with first_byte=1 in any state other than IDLE is decoded as a new command. Any pending read/write sequence is abandoned without a strobe.
- Frame end: last_byte=1 in any state. Pulse last_ack 1 cycle, pulse frame_done, go to IDLE, busy<=0, tx_data<=RD_DUMMY. last_byte is ignored in the cycle after last_ack (holdoff identical to rx). If rx_rdy and last_byte coincide, the word is processed first; frame end follows the next cycle.
- last_byte in IDLE still gets last_ack and frame_done, so spi_slave never stalls.
- reg_wr and reg_rd are never high in the same cycle. At most one strobe per accepted word.
- Address wrap: 2^ADDR_W-1 goes to 0 with no flag.
- rst asserted mid-frame returns immediately to the reset values. The bus sees no partial strobe after the reset cycle.

Test Plan:
- Write burst: frame 0x05,0xA1,0xB2,0xC3 gives reg_wr at addr 5,6,7 with data A1,B2,C3; one rx_ack per word; frame_done once at ss high.
- Read burst: regs 0x10=0x11, 0x11=0x22, 0x12=0x33; frame 0x90 then 3 dummy words gives tx_data 0x11, 0x22, 0x33 in order; reg_rd at addr 0x10,0x11,0x12,0x13; no reg_wr.
- Wrap: ADDR_W=7, write cmd 0x7F with 2 data words gives writes at addr 0x7F then 0x00.
- Resync: mid write-burst, new first_byte word 0x83 gives no write of that byte; reg_rd issued at addr 3.
- Frame end/holdoff: rx_rdy held high 1 extra cycle after rx_ack gives a single rx_ack. last_byte in IDLE gives a last_ack pulse, tx_data=0xFF, busy=0.
- Reset mid-read: rst asserted in RD_LOAD gives IDLE next cycle, tx_data=0xFF, reg_addr=0, no strobes.
